// File: rtl/cory_resample_pkg.sv
// ---------------------------------------------------------------
// cory_resample_pkg: shared state encoding and pad-mode constants (rev 1.0)
// ---------------------------------------------------------------
`default_nettype none

package cory_resample_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAD   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic PAD_REPL = 1'b0;
  localparam logic PAD_ZERO = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cory_resample_acc.sv
// ---------------------------------------------------------------
// cory_resample_acc: saturating R+1+F position accumulator (rev 1.0)
// ---------------------------------------------------------------
`default_nettype none

module cory_resample_acc #(
  parameter int R  = 11,
  parameter int F  = 8,
  parameter int RI = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            step,
  input  logic [RI+F-1:0] ratio,
  input  logic [R+F-1:0]  offset,
  input  logic [R-1:0]    in_cnt,
  output logic [R-1:0]    pos,
  output logic [F-1:0]    phase,
  output logic            beyond,
  output logic            advance
);

  localparam int AW = R + 1 + F;

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_nxt;
  logic [AW:0]   sum;

  always_comb begin
    sum     = {1'b0, acc} + {{(AW + 1 - RI - F){1'b0}}, ratio};
    acc_nxt = sum[AW] ? '1 : sum[AW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= {1'b0, offset};
    end else if (step) begin
      acc <= acc_nxt;
    end
  end

  assign pos     = acc[R+F-1:F];
  assign phase   = acc[F-1:0];
  assign beyond  = acc[R+F] | (pos >= in_cnt);
  // The overflow bit is part of the comparison so a saturating step still counts as a move.
  assign advance = acc_nxt[AW-1:F] != acc[AW-1:F];

endmodule

`default_nettype wire

// File: rtl/cory_resample.sv
// ---------------------------------------------------------------
// cory_resample: multi-channel fixed-point resampler (rev 1.0)
// ---------------------------------------------------------------
`default_nettype none

module cory_resample
  import cory_resample_pkg::*;
#(
  parameter int N  = 8,
  parameter int C  = 3,
  parameter int R  = 11,
  parameter int F  = 8,
  parameter int RI = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_cmd_v,
  input  logic [R-1:0]    i_cmd_in_cnt,
  input  logic [R-1:0]    i_cmd_out_cnt,
  input  logic [RI+F-1:0] i_cmd_ratio,
  input  logic [R+F-1:0]  i_cmd_offset,
  input  logic            i_cmd_pad,
  output logic            o_cmd_r,
  input  logic            i_a_v,
  input  logic [C*N-1:0]  i_a_d,
  output logic            o_a_r,
  output logic            o_z_v,
  output logic [C*N-1:0]  o_z_d,
  output logic [R-1:0]    o_z_cnt,
  output logic [R-1:0]    o_z_pos,
  output logic [F-1:0]    o_z_phase,
  output logic            o_z_last,
  input  logic            i_z_r
);

  state_e         state;
  logic [R-1:0]   in_cnt;
  logic [R-1:0]   out_cnt;
  logic [R-1:0]   in_idx;
  logic [R-1:0]   out_idx;
  logic [R-1:0]   in_idx_nxt;
  logic           pad_mode;
  logic [C*N-1:0] last_d;

  logic [R-1:0]   pos;
  logic [F-1:0]   phase;
  logic           beyond;
  logic           advance;

  logic           cmd_hs;
  logic           a_hs;
  logic           z_hs;
  logic           is_last;
  logic           a_r;
  logic           z_v;
  logic [C*N-1:0] z_d;

  cory_resample_acc #(
    .R  (R),
    .F  (F),
    .RI (RI)
  ) u_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (cmd_hs),
    .step    (z_hs),
    .ratio   (i_cmd_ratio),
    .offset  (i_cmd_offset),
    .in_cnt  (in_cnt),
    .pos     (pos),
    .phase   (phase),
    .beyond  (beyond),
    .advance (advance)
  );

  assign cmd_hs  = (state == ST_IDLE) & i_cmd_v;
  assign is_last = out_idx == (out_cnt - R'(1));

  always_comb begin
    a_r = 1'b0;
    z_v = 1'b0;
    z_d = '0;
    case (state)
      ST_RUN: begin
        if (!beyond) begin
          if (in_idx != pos) begin
            a_r = 1'b1;
          end else begin
            // Input is held while the same position is still needed by a later output.
            z_v = i_a_v;
            z_d = i_a_d;
            a_r = i_z_r & (advance | is_last);
          end
        end
      end
      ST_PAD: begin
        z_v = 1'b1;
        z_d = (pad_mode == PAD_ZERO) ? '0 : last_d;
      end
      ST_DRAIN: a_r = in_idx != in_cnt;
      default: ;
    endcase
  end

  assign a_hs       = i_a_v & a_r;
  assign z_hs       = z_v & i_z_r;
  assign in_idx_nxt = in_idx + {{(R-1){1'b0}}, a_hs};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      in_cnt   <= '0;
      out_cnt  <= '0;
      pad_mode <= PAD_REPL;
      in_idx   <= '0;
      out_idx  <= '0;
      last_d   <= '0;
    end else if (cmd_hs) begin
      in_cnt   <= i_cmd_in_cnt;
      out_cnt  <= i_cmd_out_cnt;
      pad_mode <= i_cmd_pad;
      in_idx   <= '0;
      out_idx  <= '0;
      last_d   <= '0;
      state    <= (i_cmd_out_cnt == '0) ? ST_DRAIN : ST_RUN;
    end else begin
      in_idx <= in_idx_nxt;
      if (a_hs) last_d <= i_a_d;
      if (z_hs) out_idx <= out_idx + R'(1);
      case (state)
        ST_RUN: begin
          if (beyond) state <= ST_PAD;
          else if (z_hs && is_last) state <= (in_idx_nxt < in_cnt) ? ST_DRAIN : ST_IDLE;
        end
        ST_PAD: begin
          if (z_hs && is_last) state <= (in_idx_nxt < in_cnt) ? ST_DRAIN : ST_IDLE;
        end
        ST_DRAIN: begin
          if (in_idx_nxt == in_cnt) state <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_r   = state == ST_IDLE;
  assign o_a_r     = a_r;
  assign o_z_v     = z_v;
  assign o_z_d     = z_d;
  assign o_z_cnt   = out_idx;
  assign o_z_pos   = pos;
  assign o_z_phase = phase;
  assign o_z_last  = z_v & is_last;

endmodule

`default_nettype wire

// File: tb/tb_cory_resample.sv
// ---------------------------------------------------------------
// tb_cory_resample: scoreboard bench for cory_resample (rev 1.0)
// ---------------------------------------------------------------
`default_nettype none

module tb_cory_resample;

  localparam int N  = 8;
  localparam int C  = 3;
  localparam int R  = 11;
  localparam int F  = 8;
  localparam int RI = 8;
  localparam int DW = C * N;

  logic            clk;
  logic            reset_n;
  logic            i_cmd_v;
  logic [R-1:0]    i_cmd_in_cnt;
  logic [R-1:0]    i_cmd_out_cnt;
  logic [RI+F-1:0] i_cmd_ratio;
  logic [R+F-1:0]  i_cmd_offset;
  logic            i_cmd_pad;
  logic            o_cmd_r;
  logic            i_a_v;
  logic [DW-1:0]   i_a_d;
  logic            o_a_r;
  logic            o_z_v;
  logic [DW-1:0]   o_z_d;
  logic [R-1:0]    o_z_cnt;
  logic [R-1:0]    o_z_pos;
  logic [F-1:0]    o_z_phase;
  logic            o_z_last;
  logic            i_z_r;

  cory_resample #(.N(N), .C(C), .R(R), .F(F), .RI(RI)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_cmd_v(i_cmd_v), .i_cmd_in_cnt(i_cmd_in_cnt), .i_cmd_out_cnt(i_cmd_out_cnt),
    .i_cmd_ratio(i_cmd_ratio), .i_cmd_offset(i_cmd_offset), .i_cmd_pad(i_cmd_pad),
    .o_cmd_r(o_cmd_r),
    .i_a_v(i_a_v), .i_a_d(i_a_d), .o_a_r(o_a_r),
    .o_z_v(o_z_v), .o_z_d(o_z_d), .o_z_cnt(o_z_cnt), .o_z_pos(o_z_pos),
    .o_z_phase(o_z_phase), .o_z_last(o_z_last), .i_z_r(i_z_r)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            cnt;
    int            pos;
    int            phase;
    bit            last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] din[$];
  int            n_cmp = 0;
  int            n_err = 0;
  bit            mon_en = 0;
  bit            rdy_stall = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    i_z_r = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_z_r = rdy_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on each output handshake and checks hold-while-stalled.
  initial begin
    bit            held_v;
    logic [DW-1:0] h_d;
    logic [R-1:0]  h_cnt, h_pos;
    logic [F-1:0]  h_ph;
    exp_t          e;
    held_v = 0;
    forever begin
      @(negedge clk);
      if (reset_n && mon_en) begin
        if (held_v) begin
          n_cmp++;
          if (!o_z_v || o_z_d !== h_d || o_z_cnt !== h_cnt || o_z_pos !== h_pos || o_z_phase !== h_ph) begin
            n_err++;
            $display("FAIL stall_hold: got v=%0b d=%h cnt=%0d pos=%0d ph=%h, required v=1 d=%h cnt=%0d pos=%0d ph=%h",
                     o_z_v, o_z_d, o_z_cnt, o_z_pos, o_z_phase, h_d, h_cnt, h_pos, h_ph);
          end
        end
        held_v = o_z_v && !i_z_r;
        h_d = o_z_d; h_cnt = o_z_cnt; h_pos = o_z_pos; h_ph = o_z_phase;
        if (o_z_v && i_z_r) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: got d=%h cnt=%0d, required no output", o_z_d, o_z_cnt);
          end else begin
            e = exp_q.pop_front();
            if (o_z_d !== e.d || int'(o_z_cnt) != e.cnt || int'(o_z_pos) != e.pos ||
                int'(o_z_phase) != e.phase || o_z_last !== e.last) begin
              n_err++;
              $display("FAIL output k=%0d: got d=%h cnt=%0d pos=%0d ph=%h last=%0b, required d=%h cnt=%0d pos=%0d ph=%h last=%0b",
                       e.cnt, o_z_d, o_z_cnt, o_z_pos, o_z_phase, o_z_last, e.d, e.cnt, e.pos, e.phase, e.last);
            end
          end
        end
      end else begin
        held_v = 0;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_r"}, o_cmd_r, 1);
    chk({tag, "_a_r"}, o_a_r, 0);
    chk({tag, "_z_v"}, o_z_v, 0);
    chk({tag, "_z_d"}, o_z_d, 0);
    chk({tag, "_z_cnt"}, o_z_cnt, 0);
    chk({tag, "_z_pos"}, o_z_pos, 0);
    chk({tag, "_z_phase"}, o_z_phase, 0);
    chk({tag, "_z_last"}, o_z_last, 0);
  endtask

  // Reference: output k reads input floor(offset + k*ratio), saturated; out-of-range reads pad.
  task automatic build_expected(input int n_in, input int n_out, input int ratio, input int off, input bit pad);
    longint        a;
    longint        amax;
    int            p;
    logic [DW-1:0] rep;
    exp_t          e;
    amax = (longint'(1) << (R + 1 + F)) - 1;
    rep  = '0;
    for (int k = 0; k < n_out; k++) begin
      a = longint'(off) + longint'(k) * longint'(ratio);
      if (a > amax) a = amax;
      p = int'(a >> F);
      if (p < n_in) begin
        e.d = din[p];
        rep = din[p];
      end else begin
        e.d = pad ? '0 : rep;
      end
      e.cnt   = k;
      e.pos   = p % (1 << R);
      e.phase = int'(a % (1 << F));
      e.last  = (k == n_out - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_cmd(input int n_in, input int n_out, input int ratio, input int off,
                         input bit pad, input bit stall);
    int idx;
    int cyc;
    bit hs;
    din.delete();
    for (int i = 0; i < n_in; i++) din.push_back(DW'($urandom));
    build_expected(n_in, n_out, ratio, off, pad);
    rdy_stall = stall;
    @(posedge clk);
    #1;
    i_cmd_v       = 1'b1;
    i_cmd_in_cnt  = R'(n_in);
    i_cmd_out_cnt = R'(n_out);
    i_cmd_ratio   = (RI+F)'(ratio);
    i_cmd_offset  = (R+F)'(off);
    i_cmd_pad     = pad;
    @(posedge clk);
    #1;
    i_cmd_v = 1'b0;
    idx = 0;
    cyc = 0;
    i_a_v = 1'b0;
    while (idx < n_in) begin
      if (!i_a_v && (!stall || $urandom_range(0, 2) != 0)) begin
        i_a_v = 1'b1;
        i_a_d = din[idx];
      end
      @(negedge clk);
      hs = i_a_v && o_a_r;
      @(posedge clk);
      #1;
      if (hs) begin
        idx++;
        i_a_v = 1'b0;
      end
      cyc++;
      if (cyc > 2000) begin
        n_cmp++;
        n_err++;
        $display("FAIL input_timeout: got %0d inputs accepted, required %0d", idx, n_in);
        break;
      end
    end
    i_a_v = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!o_cmd_r && cyc < 500);
    chk("back_to_idle", o_cmd_r, 1);
    chk("outputs_remaining", exp_q.size(), 0);
    exp_q.delete();
    rdy_stall = 0;
  endtask

  initial begin
    int n_in, n_out;
    reset_n = 1'b0;
    i_cmd_v = 1'b0; i_cmd_in_cnt = '0; i_cmd_out_cnt = '0;
    i_cmd_ratio = '0; i_cmd_offset = '0; i_cmd_pad = 1'b0;
    i_a_v = 1'b0; i_a_d = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    mon_en = 1;

    run_cmd(4, 8, 'h080, 0, 0, 0);
    run_cmd(8, 4, 'h200, 0, 0, 0);
    run_cmd(3, 6, 'h100, 0, 0, 0);
    run_cmd(3, 6, 'h100, 0, 1, 0);
    run_cmd(4, 3, 'h100, 'h180, 0, 0);
    repeat (3) run_cmd(4, 8, 'h080, 0, 0, 1);
    run_cmd(5, 0, 'h100, 0, 0, 1);
    run_cmd(0, 2, 'h100, 0, 0, 0);
    run_cmd(0, 3, 'h040, 0, 1, 1);

    // Abort a command mid-RUN with an asynchronous reset.
    mon_en = 0;
    @(posedge clk);
    #1;
    i_cmd_v = 1'b1; i_cmd_in_cnt = R'(4); i_cmd_out_cnt = R'(8);
    i_cmd_ratio = 'h080; i_cmd_offset = '0; i_cmd_pad = 1'b0;
    @(posedge clk);
    #1;
    i_cmd_v = 1'b0;
    i_a_v = 1'b1;
    i_a_d = 24'h123456;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrun_z_v", o_z_v, 1);
    chk("midrun_cmd_r", o_cmd_r, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    i_a_v = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1;
    run_cmd(4, 8, 'h080, 0, 0, 0);

    for (int t = 0; t < 20; t++) begin
      n_in  = $urandom_range(1, 12);
      n_out = $urandom_range(0, 12);
      run_cmd(n_in, n_out, $urandom_range(0, 'h300), $urandom_range(0, (n_in + 1) * 256),
              $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cory_resample.md
# cory_resample

Multi-channel fixed-point resampler that feeds a filter tap stage with a per-command sample stream. For each command it consumes exactly `in_cnt` input samples and emits exactly `out_cnt` output samples. Output k takes the input at integer position floor(offset + k·ratio). Positions beyond the input are padded by replicating the last sample or by zero, selected per command. The block sits between a line/column reader and the polyphase filter, which uses `o_z_phase` to select coefficients.

## Interface
Parameters:
- `N`, 8, bits per channel
- `C`, 3, channels per sample, all sharing one position
- `R`, 11, position/count bits
- `F`, 8, fractional phase bits
- `RI`, 8, integer bits of ratio

Ports (reset reset_n, asynchronous, active-low; clock clk):
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous active-low reset
- `i_cmd_v`  in  1  command valid
- `i_cmd_in_cnt`  in  R  input samples to consume
- `i_cmd_out_cnt`  in  R  output samples to produce
- `i_cmd_ratio`  in  RI+F  step per output, unsigned RI.F
- `i_cmd_offset`  in  R+F  initial position, unsigned R.F
- `i_cmd_pad`  in  1  0 = replicate last input, 1 = zero
- `o_cmd_r`  out  1  command ready
- `i_a_v`  in  1  input valid
- `i_a_d`  in  C·N  input sample
- `o_a_r`  out  1  input ready
- `o_z_v`  out  1  output valid
- `o_z_d`  out  C·N  output sample
- `o_z_cnt`  out  R  output index k
- `o_z_pos`  out  R  integer position
- `o_z_phase`  out  F  fractional position
- `o_z_last`  out  1  high on output k = out_cnt−1
- `i_z_r`  in  1  output ready

## Operation
- The accumulator `acc` is R+1+F bits and loads `i_cmd_offset` on command accept. On each output handshake it adds the zero-extended ratio, saturating at all-ones. pos = acc[R+F-1:F], phase = acc[F-1:0], and `beyond` = acc[R+F] or pos ≥ in_cnt.
- The input index `in_idx` counts input handshakes. The output index `out_idx` counts output handshakes.
- The `last_d` register captures `i_a_d` on every input handshake and clears to 0 on command accept.
- FSM states:
  - IDLE: `o_cmd_r`=1. Accept → RUN. If out_cnt=0, accept → DRAIN instead.
  - RUN, not beyond, in_idx < pos: skip. `o_a_r`=1, `o_z_v`=0.
  - RUN, in_idx == pos: `o_z_v` = `i_a_v` and `o_z_d` = `i_a_d`. `o_a_r` = `i_z_r` & (next pos ≠ pos, or this is the last output). Input and output handshake in the same cycle.
  - RUN, beyond: move to PAD.
  - PAD: `o_z_v`=1, `o_a_r`=0. `o_z_d` = pad ? 0 : `last_d`.
  - Final output handshake from RUN or PAD: go to DRAIN if in_idx (after update) < in_cnt, else to IDLE.
  - DRAIN: `o_a_r`=1, `o_z_v`=0. Go to IDLE when in_idx reaches in_cnt.
- in_cnt=0: every output is padding. With replicate mode the padding value is 0, because `last_d` was cleared.
- ratio=0: all outputs come from input floor(offset). Remaining inputs drain after the last output.
- Commands never overlap. A new command is accepted only in IDLE.

## Timing
- Reset values: state=IDLE; `o_cmd_r`=1; `o_a_r`=0; `o_z_v`=0; `o_z_d`=0; `o_z_cnt`/`o_z_pos`/`o_z_phase`=0; `o_z_last`=0; `acc`, `in_idx`, `out_idx`, `last_d` = 0.
- RUN latency is zero: `i_a_v` → `o_z_v` is combinational, and `i_z_r` → `o_a_r` is combinational.
- `o_z_v` never depends on `i_z_r`. `o_z_d` and the position outputs are held stable while `o_z_v` & !`i_z_r`.
- Command accept to first `o_z_v` takes 1 cycle at minimum, once state is registered.
- The last handshake of DRAIN, RUN or PAD moves the state to IDLE on the next edge, and `o_cmd_r` rises in that cycle.
- A reset mid-command aborts immediately. Partially consumed input is not recovered.

## Structure
- Package `cory_resample_pkg` holds:
  - the state encoding (IDLE, RUN, PAD, DRAIN)
  - the pad-mode constants `PAD_REPL`=0 and `PAD_ZERO`=1
- Sub-module `cory_resample_acc` holds the saturating R+1+F phase accumulator. Its interface is load, step, ratio, offset, pos, phase and beyond.
- The FSM, counters, `last_d` and handshake muxing live in `cory_resample`.

## Test plan
- in=4, out=8, ratio=0x080 (0.5), offset=0, inputs A,B,C,D → A,A,B,B,C,C,D,D. Phases alternate 00/80, and o_z_last is high on k=7.
- in=8, out=4, ratio=0x200, inputs 0..7 → 0,2,4,6. Inputs 1,3,5 are skipped and 7 is drained. Back in IDLE after 8 input handshakes.
- in=3, out=6, ratio=0x100, pad=0 → d0,d1,d2,d2,d2,d2. Repeat with pad=1 → d0,d1,d2,0,0,0.
- in=4, out=3, ratio=0x100, offset=0x180 → outputs d1,d2,d3 with phase 0x80, and input d0 is skipped.
- Random `i_a_v` / `i_z_r` stalls on scenario 1 → identical data and position sequence, and outputs stable while stalled.
- Edge cases:
  - out=0, in=5 → 5 inputs drained, no outputs.
  - in=0, out=2, pad=0 → two zero outputs.
  - reset asserted mid-RUN → all outputs at reset values, next command processed cleanly.
